pipe_flush_ctrl: RTL and testbench
==================================

// Module: pipe_flush_ctrl
// PURPOSE
//  Central pipeline sequencer for the 5-stage core. Merges per-stage stall requests into the stall[5:0]
//  vector that every inter-stage register (pc, if_id, id_ex, ex_mem, mem_wb) consumes.
//  Sequences exception/ERET entry as FREEZE -> FLUSH -> DRAIN and drives flush + new_pc.
//  Includes a stall watchdog.
// PARAMETERS
//  EXC_VECTOR    32'h0000_0020  redirect PC for every exception except ERET
//  DRAIN_CYCLES  3              cycles after flush during which new exceptions are ignored (1..15)
//  STALL_TIMEOUT 16'd1024       consecutive request-stall cycles before stall_timeout_o pulses
// PORTS
//  clk              in   1   clock, all state on posedge
//  rst              in   1   synchronous reset, active-high
//  stallreq_if_i    in   1   fetch stage stall request
//  stallreq_id_i    in   1   decode stage stall request
//  stallreq_ex_i    in   1   execute stage stall request (multi-cycle ALU ops)
//  stallreq_mem_i   in   1   memory stage stall request (bus wait)
//  excepttype_i     in   32  exception cause from MEM stage; 0 = none, 32'h0000_000e = ERET
//  cp0_epc_i        in   32  current EPC from CP0
//  stall            out  6   [0]pc [1]if [2]id [3]ex [4]mem [5]wb; 1 = hold
//  flush            out  1   clear all pipeline registers this cycle
//  new_pc           out  32  redirect target, valid only while flush=1
//  stall_timeout_o  out  1   one-cycle pulse on watchdog expiry
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, drain_cnt=0, stall_cnt=0, latched cause/epc=0.
//   Registered outputs return to flush=0, new_pc=0, stall_timeout_o=0.
//   While rst is held, stall=6'b000000 (the combinational output is forced low).
//  States: IDLE, FREEZE, FLUSH, DRAIN.
//  IDLE, excepttype_i==0: stall is combinational, same cycle. Priority mem > ex > id > if:
//   mem 6'b011111, ex 6'b001111, id 6'b000111, if 6'b000111, none 6'b000000.
//  IDLE, excepttype_i!=0: stall=6'b111111 in the same cycle (combinational). Exception wins over any stall request.
//   Latch excepttype_i and cp0_epc_i, then go to FREEZE.
//  FREEZE (1 cycle): stall=6'b111111, flush=0. Next state FLUSH.
//  FLUSH (1 cycle): flush=1, stall=6'b000000.
//   new_pc = latched epc if latched cause==32'h0000_000e, else EXC_VECTOR.
//   Next state DRAIN, drain_cnt<=DRAIN_CYCLES-1.
//  DRAIN: excepttype_i is ignored. Stall requests are honoured exactly as in IDLE; drain_cnt still decrements.
//   At drain_cnt==0, go to IDLE.
//  flush and new_pc are registered from the next state, so they are high exactly in the FLUSH-state cycle.
//   new_pc=0 in every other cycle.
//  Watchdog: stall_cnt (16b) increments each cycle that stall[0]=1 due to a stall request.
//   Cycles where stall[0]=1 only because of FREEZE do not count.
//   stall_cnt clears on any cycle without a request-stall.
//   When stall_cnt==STALL_TIMEOUT-1 and the request persists, stall_timeout_o pulses for 1 cycle and stall_cnt wraps to 0.
//   Stall is not released by timeout.
//  rst mid-FREEZE/FLUSH/DRAIN: abort to IDLE; pending redirect is discarded.
//  Exceptions arriving while in FREEZE/FLUSH are ignored; the MEM stage is held or cleared at that point.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined: adds outputs perf_stall_cycles_o[31:0] and perf_flush_cnt_o[31:0].
//   perf_stall_cycles_o counts cycles with stall[0]=1; perf_flush_cnt_o counts FLUSH entries.
//   Both wrap at 2^32 and reset to 0.
//  PIPE_CTRL_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  stallreq_ex_i=1 and stallreq_id_i=1 for 3 cycles
//   -> stall=6'b001111 each cycle, 6'b000000 after; flush stays 0.
//  excepttype_i=32'h0000_0008 for 1 cycle in IDLE
//   -> stall=111111 for 2 cycles; flush=1 on cycle 3 with new_pc=32'h20; IDLE after 3 DRAIN cycles.
//  excepttype_i=32'h0000_000e with cp0_epc_i=32'h0000_1234
//   -> flush cycle shows new_pc=32'h0000_1234.
//  stallreq_mem_i and excepttype_i=1 in the same cycle
//   -> stall=111111 (not 011111); exception sequence proceeds.
//  Second exception asserted during DRAIN -> no second flush.
//  Exception right after DRAIN ends -> a full new FREEZE/FLUSH sequence.
//  stallreq_mem_i held 1030 cycles (STALL_TIMEOUT=1024) -> one stall_timeout_o pulse at request-cycle 1024.
//  rst asserted in FREEZE -> next cycle IDLE, flush=0, stall=0.

Source files
------------

// File: rtl/pipe_flush_ctrl.sv
// Pipeline sequencer: merges stage stall requests, runs the FREEZE->FLUSH->DRAIN exception entry, stall watchdog.
// Optional perf counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_flush_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'h0000_0020,
    parameter int unsigned DRAIN_CYCLES  = 3,
    parameter logic [15:0] STALL_TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] perf_stall_cycles_o,
    output logic [31:0] perf_flush_cnt_o,
`endif
    output logic        stall_timeout_o
);

    localparam logic [31:0] ERET_CAUSE = 32'h0000_000e;
    localparam logic [3:0]  DRAIN_INIT = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, FREEZE, FLUSH, DRAIN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  drain_cnt_q, drain_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic        flush_q;
    logic [31:0] new_pc_q;
    logic        timeout_q, timeout_d;
    logic [5:0]  req_vec;
    logic        any_req;
    logic        req_active;
    logic [5:0]  stall_comb;
    logic [31:0] redirect;

    always_comb begin
        req_vec = 6'b000000;
        if (stallreq_mem_i)      req_vec = 6'b011111;
        else if (stallreq_ex_i)  req_vec = 6'b001111;
        else if (stallreq_id_i)  req_vec = 6'b000111;
        else if (stallreq_if_i)  req_vec = 6'b000111;
    end

    assign any_req  = stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
    assign redirect = (cause_q == ERET_CAUSE) ? epc_q : EXC_VECTOR;

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        stall_comb  = 6'b000000;
        req_active  = 1'b0;
        case (state_q)
            IDLE: begin
                if (excepttype_i != 32'd0) begin
                    stall_comb = 6'b111111;
                    cause_d    = excepttype_i;
                    epc_d      = cp0_epc_i;
                    state_d    = FREEZE;
                end else begin
                    stall_comb = req_vec;
                    req_active = any_req;
                end
            end
            FREEZE: begin
                stall_comb = 6'b111111;
                state_d    = FLUSH;
            end
            FLUSH: begin
                state_d     = DRAIN;
                drain_cnt_d = DRAIN_INIT;
            end
            DRAIN: begin
                stall_comb = req_vec;
                req_active = any_req;
                if (drain_cnt_q == 4'd0) state_d = IDLE;
                else                     drain_cnt_d = drain_cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Watchdog only counts stalls caused by requests, never the FREEZE hold.
    always_comb begin
        stall_cnt_d = 16'd0;
        timeout_d   = 1'b0;
        if (req_active) begin
            if (stall_cnt_q == STALL_TIMEOUT - 16'd1) timeout_d = 1'b1;
            else                                      stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            drain_cnt_q <= 4'd0;
            stall_cnt_q <= 16'd0;
            cause_q     <= 32'd0;
            epc_q       <= 32'd0;
            flush_q     <= 1'b0;
            new_pc_q    <= 32'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            flush_q     <= (state_d == FLUSH);
            new_pc_q    <= (state_d == FLUSH) ? redirect : 32'd0;
            timeout_q   <= timeout_d;
        end
    end

    assign stall           = rst ? 6'b000000 : stall_comb;
    assign flush           = flush_q;
    assign new_pc          = new_pc_q;
    assign stall_timeout_o = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (stall[0])                                 perf_stall_q <= perf_stall_q + 32'd1;
            if (state_d == FLUSH && state_q != FLUSH)     perf_flush_q <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cycles_o = perf_stall_q;
    assign perf_flush_cnt_o    = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_flush_ctrl.sv
// Self-checking bench for pipe_flush_ctrl: table-driven stall vectors plus scoreboarded exception/reset/watchdog sequences.
module tb_pipe_flush_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_cycles_o, perf_flush_cnt_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_flush_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_if_i   (stallreq_if_i),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .stallreq_mem_i  (stallreq_mem_i),
        .excepttype_i    (excepttype_i),
        .cp0_epc_i       (cp0_epc_i),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
`ifdef PIPE_CTRL_PERF_EN
        .perf_stall_cycles_o (perf_stall_cycles_o),
        .perf_flush_cnt_o    (perf_flush_cnt_o),
`endif
        .stall_timeout_o (stall_timeout_o)
    );

    typedef struct {
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] pc;
        logic        to;
    } exp_t;

    typedef struct {
        logic       r_if, r_id, r_ex, r_mem;
        logic [5:0] exp;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Push the expectation for the current cycle, compare at negedge, advance to just after the next posedge.
    task automatic step(input string name, input logic [5:0] es, input logic ef,
                        input logic [31:0] ep, input logic eto);
        exp_t e;
        exp_t got;
        e.stall = es; e.flush = ef; e.pc = ep; e.to = eto;
        sb.push_back(e);
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            got = sb.pop_front();
            chk({name, ".stall"},   {26'd0, stall},            {26'd0, got.stall});
            chk({name, ".flush"},   {31'd0, flush},            {31'd0, got.flush});
            chk({name, ".new_pc"},  new_pc,                    got.pc);
            chk({name, ".timeout"}, {31'd0, stall_timeout_o},  {31'd0, got.to});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic a, input logic b, input logic c, input logic d);
        stallreq_if_i = a; stallreq_id_i = b; stallreq_ex_i = c; stallreq_mem_i = d;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'b011111};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000111};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 6'b011111};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'b001111};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
        vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        excepttype_i = 32'd0;
        cp0_epc_i    = 32'd0;
        @(posedge clk); #1;
        step("reset0", 6'b000000, 1'b0, 32'd0, 1'b0);
        step("reset1", 6'b000000, 1'b0, 32'd0, 1'b0);

        rst = 1'b0;
        foreach (vecs[i]) begin
            set_req(vecs[i].r_if, vecs[i].r_id, vecs[i].r_ex, vecs[i].r_mem);
            step($sformatf("vec%0d", i), vecs[i].exp, 1'b0, 32'd0, 1'b0);
        end

        set_req(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("exid", 6'b001111, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step("exid_rel", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Exception 8 -> vector, second exception in DRAIN ignored, requests honoured in DRAIN.
        excepttype_i = 32'h8;
        step("exc_idle", 6'b111111, 1'b0, 32'd0, 1'b0);
        excepttype_i = 32'h0;
        step("exc_freeze", 6'b111111, 1'b0, 32'd0, 1'b0);
        step("exc_flush", 6'b000000, 1'b1, 32'h20, 1'b0);
        excepttype_i = 32'h4;
        step("drain1", 6'b000000, 1'b0, 32'd0, 1'b0);
        step("drain2", 6'b000000, 1'b0, 32'd0, 1'b0);
        excepttype_i = 32'h0;
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        step("drain3_req", 6'b011111, 1'b0, 32'd0, 1'b0);

        // ERET straight after DRAIN, with a colliding mem stall and junk during FREEZE.
        excepttype_i = 32'he;
        cp0_epc_i    = 32'h0000_1234;
        step("eret_idle", 6'b111111, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        excepttype_i = 32'h8;
        cp0_epc_i    = 32'h0000_5678;
        step("eret_freeze", 6'b111111, 1'b0, 32'd0, 1'b0);
        excepttype_i = 32'h0;
        step("eret_flush", 6'b000000, 1'b1, 32'h0000_1234, 1'b0);
        for (int i = 0; i < 3; i++) step("eret_drain", 6'b000000, 1'b0, 32'd0, 1'b0);
        step("post_idle", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Reset in FREEZE aborts the redirect.
        excepttype_i = 32'h8;
        step("rst_exc", 6'b111111, 1'b0, 32'd0, 1'b0);
        excepttype_i = 32'h0;
        rst = 1'b1;
        step("rst_freeze", 6'b000000, 1'b0, 32'd0, 1'b0);
        rst = 1'b0;
        set_req(1'b1, 1'b0, 1'b0, 1'b0);
        step("rst_idle_req", 6'b000111, 1'b0, 32'd0, 1'b0);
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step("rst_after1", 6'b000000, 1'b0, 32'd0, 1'b0);
        step("rst_after2", 6'b000000, 1'b0, 32'd0, 1'b0);

        // Watchdog: registered pulse visible in the cycle after request-cycle 1024.
        set_req(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 1030; k++)
            step("wdog", 6'b011111, 1'b0, 32'd0, (k == 1025));
        set_req(1'b0, 1'b0, 1'b0, 1'b0);
        step("wdog_rel", 6'b000000, 1'b0, 32'd0, 1'b0);

        if (sb.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_leftover: got %0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
